// File: rtl/l1cache_pkg.sv
// Shared types and width helpers for the direct-mapped L1 data cache.
// The cache top and its data array both import this package.
package l1cache_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        LOOKUP,
        EVICT,
        FILL,
        WT_WRITE
    } state_t;

    function automatic int unsigned offset_width(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned index_width(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_width(input int unsigned sets, input int unsigned line_words);
        return 32 - 2 - offset_width(line_words) - index_width(sets);
    endfunction

    // A one-word line still needs a 1-bit counter/word select.
    function automatic int unsigned count_width(input int unsigned line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

endpackage

// File: rtl/l1cache_data_array.sv
// Line data storage: SETS x LINE_WORDS x 32 bits, asynchronous read on two
// word ports of one set, byte-enabled synchronous write.
module l1cache_data_array
    import l1cache_pkg::*;
#(
    parameter int unsigned SETS       = 16,
    parameter int unsigned LINE_WORDS = 4,
    localparam int unsigned IW = index_width(SETS),
    localparam int unsigned CW = count_width(LINE_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] set,
    input  logic [CW-1:0] wr_word,
    input  word_t         wdata,
    input  logic [3:0]    be,
    input  logic [CW-1:0] rd_word_a,
    input  logic [CW-1:0] rd_word_b,
    output word_t         rdata_a,
    output word_t         rdata_b
);

    word_t mem [SETS][LINE_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) mem[set][wr_word][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata_a = mem[set][rd_word_a];
    assign rdata_b = mem[set][rd_word_b];

endmodule

// File: rtl/l1cache_wb.sv
// Direct-mapped L1 data cache between an Avalon-MM CPU master and a RAM slave.
// WRITE_BACK selects write-back/write-allocate or write-through/no-allocate.
module l1cache_wb
    import l1cache_pkg::*;
#(
    parameter int unsigned SETS       = 16,
    parameter int unsigned LINE_WORDS = 4,
    parameter bit          WRITE_BACK = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       read_cpu,
    input  logic       write_cpu,
    input  addr_t      addr_cpu,
    input  logic [3:0] byteenable_cpu,
    input  word_t      writedata_cpu,
    output word_t      readdata_cpu,
    output logic       waitrequest_cpu,
    output logic       read_ram,
    output logic       write_ram,
    output addr_t      addr_ram,
    output logic [3:0] byteenable_ram,
    output word_t      writedata_ram,
    input  word_t      readdata_ram,
    input  logic       waitrequest_ram
);

    localparam int unsigned OW = offset_width(LINE_WORDS);
    localparam int unsigned IW = index_width(SETS);
    localparam int unsigned TW = tag_width(SETS, LINE_WORDS);
    localparam int unsigned CW = count_width(LINE_WORDS);
    localparam addr_t         LINE_MASK = addr_t'(4 * LINE_WORDS - 1);
    localparam logic [CW-1:0] LAST      = CW'(LINE_WORDS - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, off, ev_word, arr_word;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [TW-1:0] tags [SETS];
    logic [SETS-1:0] valid, dirty;

    word_t      rdata_a, rdata_b, arr_wdata, wdata_n;
    logic [3:0] arr_be, be_n;
    addr_t      addr_n, line_base, victim_base;
    logic       arr_we, hit, accept, start_miss, fill_done, set_dirty;
    logic       read_n, write_n;

    assign off         = CW'((addr_cpu >> 2) & addr_t'(LINE_WORDS - 1));
    assign idx         = IW'(addr_cpu >> (2 + OW));
    assign tag         = TW'(addr_cpu >> (2 + OW + IW));
    assign hit         = valid[idx] && (tags[idx] == tag);
    assign line_base   = addr_cpu & ~LINE_MASK;
    assign victim_base = (addr_t'(tags[idx]) << (2 + OW + IW)) | (addr_t'(idx) << (2 + OW));
    assign accept      = (read_ram || write_ram) && !waitrequest_ram;
    // Port B prefetches the next victim word so writedata_ram can be registered.
    assign ev_word     = (state == EVICT && cnt != LAST) ? cnt + CW'(1) : '0;

    l1cache_data_array #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS)
    ) u_data (
        .clk       (clk),
        .we        (arr_we),
        .set       (idx),
        .wr_word   (arr_word),
        .wdata     (arr_wdata),
        .be        (arr_be),
        .rd_word_a (off),
        .rd_word_b (ev_word),
        .rdata_a   (rdata_a),
        .rdata_b   (rdata_b)
    );

    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        read_n          = read_ram;
        write_n         = write_ram;
        addr_n          = addr_ram;
        wdata_n         = writedata_ram;
        be_n            = byteenable_ram;
        arr_we          = 1'b0;
        arr_word        = off;
        arr_wdata       = writedata_cpu;
        arr_be          = byteenable_cpu;
        start_miss      = 1'b0;
        fill_done       = 1'b0;
        set_dirty       = 1'b0;
        waitrequest_cpu = 1'b0;
        readdata_cpu    = '0;
        unique case (state)
            LOOKUP: begin
                if (write_cpu) begin
                    if (!WRITE_BACK) begin
                        waitrequest_cpu = 1'b1;
                        state_n         = WT_WRITE;
                        write_n         = 1'b1;
                        addr_n          = addr_cpu & ~addr_t'(3);
                        wdata_n         = writedata_cpu;
                        be_n            = byteenable_cpu;
                    end else if (hit) begin
                        arr_we    = 1'b1;
                        set_dirty = 1'b1;
                    end else begin
                        waitrequest_cpu = 1'b1;
                        start_miss      = 1'b1;
                    end
                end else if (read_cpu) begin
                    if (hit) begin
                        readdata_cpu = rdata_a;
                    end else begin
                        waitrequest_cpu = 1'b1;
                        start_miss      = 1'b1;
                    end
                end
            end
            EVICT: begin
                waitrequest_cpu = 1'b1;
                if (accept) begin
                    if (cnt == LAST) begin
                        state_n = FILL;
                        cnt_n   = '0;
                        write_n = 1'b0;
                        read_n  = 1'b1;
                        addr_n  = line_base;
                    end else begin
                        cnt_n   = cnt + CW'(1);
                        addr_n  = addr_ram + addr_t'(4);
                        wdata_n = rdata_b;
                    end
                end
            end
            FILL: begin
                waitrequest_cpu = 1'b1;
                if (accept) begin
                    arr_we    = 1'b1;
                    arr_word  = cnt;
                    arr_wdata = readdata_ram;
                    arr_be    = 4'hF;
                    if (cnt == LAST) begin
                        state_n   = LOOKUP;
                        cnt_n     = '0;
                        read_n    = 1'b0;
                        fill_done = 1'b1;
                    end else begin
                        cnt_n  = cnt + CW'(1);
                        addr_n = addr_ram + addr_t'(4);
                    end
                end
            end
            WT_WRITE: begin
                waitrequest_cpu = waitrequest_ram;
                if (accept) begin
                    state_n = LOOKUP;
                    write_n = 1'b0;
                    be_n    = 4'hF;
                    arr_we  = hit;
                end
            end
            default: state_n = LOOKUP;
        endcase
        if (start_miss) begin
            cnt_n = '0;
            be_n  = 4'hF;
            if (valid[idx] && dirty[idx]) begin
                state_n = EVICT;
                write_n = 1'b1;
                addr_n  = victim_base;
                wdata_n = rdata_b;
            end else begin
                state_n = FILL;
                read_n  = 1'b1;
                addr_n  = line_base;
            end
        end
    end

    // The line is invalidated when the miss starts, so an aborted fill never hits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= LOOKUP;
            cnt            <= '0;
            valid          <= '0;
            dirty          <= '0;
            read_ram       <= 1'b0;
            write_ram      <= 1'b0;
            addr_ram       <= '0;
            writedata_ram  <= '0;
            byteenable_ram <= 4'hF;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            read_ram       <= read_n;
            write_ram      <= write_n;
            addr_ram       <= addr_n;
            writedata_ram  <= wdata_n;
            byteenable_ram <= be_n;
            if (start_miss) valid[idx] <= 1'b0;
            if (fill_done) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
            if (set_dirty && WRITE_BACK) dirty[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) tags[idx] <= tag;
    end

endmodule

// File: tb/tb_l1cache_wb.sv
// Bench for l1cache_wb: a write-back and a write-through instance, each with its
// own RAM model, checked against a line-residency model and a flat golden memory.
module tb_l1cache_wb;
    import l1cache_pkg::*;

    localparam int LW   = 4;
    localparam int SETS = 16;
    localparam int MEMW = 1024;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       rd_req = 1'b0, wr_req = 1'b0;
    addr_t      a_cpu = '0;
    word_t      wd_cpu = '0;
    logic [3:0] be_cpu = '0;
    int         sel = 0;

    logic       read_cpu_s [2], write_cpu_s [2], wait_cpu_s [2];
    word_t      readdata_cpu_s [2];
    logic       read_ram_s [2], write_ram_s [2];
    addr_t      addr_ram_s [2];
    logic [3:0] be_ram_s [2];
    word_t      wdata_ram_s [2], rdata_ram_s [2];
    logic       wr_stall [2] = '{1'b0, 1'b0};

    word_t ram [2][MEMW];
    word_t gm [2][MEMW];
    int    res_line [2][SETS];
    bit    res_dirty [2][SETS];

    int compared = 0, mismatched = 0;
    int n_rd [2] = '{0, 0}, n_wr [2] = '{0, 0};
    addr_t rlog0 [$], wlog0_a [$];
    word_t wlog0_d [$];
    addr_t wl1_a;
    word_t wl1_d;
    logic [3:0] wl1_be;
    bit    stall_en = 1'b0, abort = 1'b0;
    addr_t force_addr = '0;
    int    force_left = 0;
    bit    held [2] = '{1'b0, 1'b0};
    addr_t h_addr [2];
    word_t h_data [2];
    logic [5:0] h_ctl [2];

    assign read_cpu_s[0]  = rd_req && (sel == 0);
    assign write_cpu_s[0] = wr_req && (sel == 0);
    assign read_cpu_s[1]  = rd_req && (sel == 1);
    assign write_cpu_s[1] = wr_req && (sel == 1);
    assign rdata_ram_s[0] = ram[0][addr_ram_s[0][11:2]];
    assign rdata_ram_s[1] = ram[1][addr_ram_s[1][11:2]];

    l1cache_wb #(.SETS(SETS), .LINE_WORDS(LW), .WRITE_BACK(1'b1)) dut_wb (
        .clk(clk), .reset(reset),
        .read_cpu(read_cpu_s[0]), .write_cpu(write_cpu_s[0]), .addr_cpu(a_cpu),
        .byteenable_cpu(be_cpu), .writedata_cpu(wd_cpu),
        .readdata_cpu(readdata_cpu_s[0]), .waitrequest_cpu(wait_cpu_s[0]),
        .read_ram(read_ram_s[0]), .write_ram(write_ram_s[0]), .addr_ram(addr_ram_s[0]),
        .byteenable_ram(be_ram_s[0]), .writedata_ram(wdata_ram_s[0]),
        .readdata_ram(rdata_ram_s[0]), .waitrequest_ram(wr_stall[0])
    );

    l1cache_wb #(.SETS(SETS), .LINE_WORDS(LW), .WRITE_BACK(1'b0)) dut_wt (
        .clk(clk), .reset(reset),
        .read_cpu(read_cpu_s[1]), .write_cpu(write_cpu_s[1]), .addr_cpu(a_cpu),
        .byteenable_cpu(be_cpu), .writedata_cpu(wd_cpu),
        .readdata_cpu(readdata_cpu_s[1]), .waitrequest_cpu(wait_cpu_s[1]),
        .read_ram(read_ram_s[1]), .write_ram(write_ram_s[1]), .addr_ram(addr_ram_s[1]),
        .byteenable_ram(be_ram_s[1]), .writedata_ram(wdata_ram_s[1]),
        .readdata_ram(rdata_ram_s[1]), .waitrequest_ram(wr_stall[1])
    );

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    function automatic word_t merge(word_t old, word_t nw, logic [3:0] be);
        word_t r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // RAM slaves: zero-latency read data, transfers complete on unstalled edges.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            held[d] = (read_ram_s[d] || write_ram_s[d]) && wr_stall[d];
            h_addr[d] = addr_ram_s[d];
            h_data[d] = wdata_ram_s[d];
            h_ctl[d] = {read_ram_s[d], write_ram_s[d], be_ram_s[d]};
            if (read_ram_s[d] && !wr_stall[d]) begin
                n_rd[d]++;
                chk("ram_read_addr_in_range", 32'(addr_ram_s[d] < 32'd4096), 32'd1);
                if (d == 0) rlog0.push_back(addr_ram_s[d]);
            end
            if (write_ram_s[d] && !wr_stall[d]) begin
                n_wr[d]++;
                chk("ram_write_addr_in_range", 32'(addr_ram_s[d] < 32'd4096), 32'd1);
                ram[d][addr_ram_s[d][11:2]] = merge(ram[d][addr_ram_s[d][11:2]], wdata_ram_s[d], be_ram_s[d]);
                if (d == 0) begin
                    wlog0_a.push_back(addr_ram_s[d]);
                    wlog0_d.push_back(wdata_ram_s[d]);
                end else begin
                    wl1_a = addr_ram_s[d];
                    wl1_d = wdata_ram_s[d];
                    wl1_be = be_ram_s[d];
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (d == 0 && force_left > 0 && read_ram_s[0] && addr_ram_s[0] == force_addr) begin
                wr_stall[0] = 1'b1;
                force_left--;
            end else begin
                wr_stall[d] = stall_en && ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Stalled RAM requests must be presented unchanged in the next cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (held[d] && !reset) begin
                chk("ram_hold_addr", addr_ram_s[d], h_addr[d]);
                chk("ram_hold_writedata", wdata_ram_s[d], h_data[d]);
                chk("ram_hold_strobes_be", 32'({read_ram_s[d], write_ram_s[d], be_ram_s[d]}), 32'(h_ctl[d]));
            end
        end
    end

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < SETS; s++) begin
                res_line[d][s] = -1;
                res_dirty[d][s] = 1'b0;
            end
    endtask

    task automatic xact(input int d, input bit rd, input bit wr, input addr_t a,
                        input word_t wd, input logic [3:0] be,
                        output word_t got_rd, output int got_waits);
        int widx = int'(a[11:2]);
        int line = int'(a[11:4]);
        int s = line % SETS;
        int base = 0, exp_r = 0, exp_w = 0, stalls = 0;
        int r0 = n_rd[d], w0 = n_wr[d];
        bit done = 1'b0;
        word_t exp_rd;
        got_rd = '0;
        got_waits = 0;
        if (abort) return;
        if (wr && d == 1) begin
            base = 1;
            exp_w = 1;
        end else begin
            if (res_line[d][s] != line) begin
                base = LW + 1;
                exp_r = LW;
                if (res_line[d][s] >= 0 && res_dirty[d][s]) begin
                    base += LW;
                    exp_w = LW;
                end
                res_line[d][s] = line;
                res_dirty[d][s] = 1'b0;
            end
            if (wr) res_dirty[d][s] = 1'b1;
        end
        exp_rd = gm[d][widx];
        if (wr) gm[d][widx] = merge(gm[d][widx], wd, be);

        @(posedge clk);
        #1;
        sel = d; a_cpu = a; wd_cpu = wd; be_cpu = be; rd_req = rd; wr_req = wr;
        while (!done) begin
            @(negedge clk);
            if (!wait_cpu_s[d]) begin
                got_rd = readdata_cpu_s[d];
                done = 1'b1;
            end else begin
                if ((read_ram_s[d] || write_ram_s[d]) && wr_stall[d]) stalls++;
                if (rd && !wr) chk("readdata_zero_while_waiting", readdata_cpu_s[d], 32'd0);
                got_waits++;
                if (got_waits > 200) begin
                    compared++;
                    mismatched++;
                    $display("FAIL completion_timeout: dut %0d addr 0x%08h still waiting after %0d cycles, required completion",
                             d, a, got_waits);
                    abort = 1'b1;
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        rd_req = 1'b0; wr_req = 1'b0;
        if (abort) return;
        chk("latency", 32'(got_waits), 32'(base + stalls));
        if (rd && !wr) chk("read_data", got_rd, exp_rd);
        chk("ram_read_count", 32'(n_rd[d] - r0), 32'(exp_r));
        chk("ram_write_count", 32'(n_wr[d] - w0), 32'(exp_w));
        @(negedge clk);
        chk("idle_waitrequest", 32'(wait_cpu_s[d]), 32'd0);
        chk("idle_readdata", readdata_cpu_s[d], 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        word_t rdv;
        int    wt;
        bit    found;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < MEMW; i++) begin
                ram[d][i] = word_t'(16 * i + 1);
                gm[d][i]  = word_t'(16 * i + 1);
            end
        model_reset();

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_read_ram", 32'(read_ram_s[d]), 32'd0);
            chk("reset_write_ram", 32'(write_ram_s[d]), 32'd0);
            chk("reset_addr_ram", addr_ram_s[d], 32'd0);
            chk("reset_writedata_ram", wdata_ram_s[d], 32'd0);
            chk("reset_byteenable_ram", 32'(be_ram_s[d]), 32'hF);
            chk("reset_readdata_cpu", readdata_cpu_s[d], 32'd0);
            chk("reset_waitrequest_cpu", 32'(wait_cpu_s[d]), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed sequence on the write-back instance.
        rlog0.delete();
        xact(0, 1, 0, 32'h40, '0, 4'h0, rdv, wt);
        chk("cold_miss_waits", 32'(wt), 32'd5);
        chk("cold_miss_data", rdv, 32'd257);
        chk("cold_miss_nreads", 32'(rlog0.size()), 32'd4);
        for (int i = 0; i < rlog0.size() && i < 4; i++) chk("cold_miss_read_addr", rlog0[i], 32'(32'h40 + 4 * i));

        xact(0, 1, 0, 32'h44, '0, 4'h0, rdv, wt);
        chk("hit_waits", 32'(wt), 32'd0);
        chk("hit_data", rdv, 32'd273);

        xact(0, 0, 1, 32'h44, 32'hDEADBEEF, 4'b0011, rdv, wt);
        chk("write_hit_waits", 32'(wt), 32'd0);
        xact(0, 1, 0, 32'h44, '0, 4'h0, rdv, wt);
        chk("merged_read", rdv, 32'h0000BEEF);

        rlog0.delete(); wlog0_a.delete(); wlog0_d.delete();
        xact(0, 1, 0, 32'h440, '0, 4'h0, rdv, wt);
        chk("dirty_miss_waits", 32'(wt), 32'd9);
        chk("dirty_miss_data", rdv, 32'd4353);
        chk("evict_nwrites", 32'(wlog0_a.size()), 32'd4);
        for (int i = 0; i < wlog0_a.size() && i < 4; i++) chk("evict_addr", wlog0_a[i], 32'(32'h40 + 4 * i));
        if (wlog0_d.size() > 1) chk("evict_word1_data", wlog0_d[1], 32'h0000BEEF);
        chk("refill_nreads", 32'(rlog0.size()), 32'd4);
        for (int i = 0; i < rlog0.size() && i < 4; i++) chk("refill_addr", rlog0[i], 32'(32'h440 + 4 * i));

        force_addr = 32'h48;
        force_left = 3;
        xact(0, 1, 0, 32'h40, '0, 4'h0, rdv, wt);
        chk("stalled_fill_waits", 32'(wt), 32'd8);
        chk("stalled_fill_data", rdv, 32'd257);
        chk("stall_cycles_applied_at_0x48", 32'(force_left), 32'd0);

        // Write-through instance.
        xact(1, 0, 1, 32'h80, 32'h12345678, 4'b1000, rdv, wt);
        chk("wt_waits", 32'(wt), 32'd1);
        chk("wt_addr", wl1_a, 32'h80);
        chk("wt_data", wl1_d, 32'h12345678);
        chk("wt_byteenable", 32'(wl1_be), 32'h8);

        // Reset in the middle of a fill.
        @(posedge clk);
        #1;
        sel = 0; a_cpu = 32'h100; rd_req = 1'b1; wr_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (read_ram_s[0] && addr_ram_s[0] == 32'h108) found = 1'b1;
        end
        if (!found) begin
            compared++;
            mismatched++;
            $display("FAIL reset_test_fill_word2: read of 0x108 never presented, required within 50 cycles");
        end
        #1;
        reset = 1'b1;
        #1;
        chk("reset_drops_read_ram", 32'(read_ram_s[0]), 32'd0);
        chk("reset_clears_addr_ram", addr_ram_s[0], 32'd0);
        rd_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        rlog0.delete();
        xact(0, 1, 0, 32'h40, '0, 4'h0, rdv, wt);
        chk("post_reset_miss_waits", 32'(wt), 32'd5);
        chk("post_reset_nreads", 32'(rlog0.size()), 32'd4);
        chk("post_reset_data", rdv, 32'd257);

        // Randomized traffic with random RAM stalls.
        stall_en = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 250; i++) begin
                int    op   = $urandom_range(0, 9);
                addr_t ra   = (addr_t'($urandom_range(0, 63)) << 4) | addr_t'($urandom_range(0, 15));
                bit    rd   = (op < 5) || (op == 9);
                bit    wr   = (op >= 5);
                xact(d, rd, wr, ra, word_t'($urandom), 4'($urandom_range(0, 15)), rdv, wt);
            end
        end
        stall_en = 1'b0;

        // RAM must match the golden image except for lines held dirty in the cache.
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < MEMW; w++) begin
                int line = w / LW;
                if (!(res_line[d][line % SETS] == line && res_dirty[d][line % SETS]))
                    chk("ram_image", ram[d][w], gm[d][w]);
            end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/l1cache_wb.md
# l1cache_wb

Parametrised successor to the write-through L1 cache: a direct-mapped cache between the CPU's Avalon-MM data master and the RAM slave, with configurable set count and line length. It is write-back/write-allocate with dirty-line eviction, or the legacy write-through/no-allocate mode, selected at elaboration. It drops in wherever `l1cache` sits, with identical CPU-side and RAM-side port sets.

## Interface
- `SETS`, 16, number of lines; power of two, ≥2
- `LINE_WORDS`, 4, 32-bit words per line; power of two, ≥1
- `WRITE_BACK`, 1, 1 = write-back + write-allocate; 0 = write-through + no-allocate
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all valid/dirty bits and returns the FSM to LOOKUP
- `read_cpu` / `write_cpu`  in  1  CPU request strobes
- `addr_cpu`  in  32  byte address; bits [1:0] ignored
- `byteenable_cpu`  in  4  write byte lanes; ignored on reads
- `writedata_cpu`  in  32  write data
- `readdata_cpu`  out  32  read data; valid in the cycle where `read_cpu`=1 and `waitrequest_cpu`=0, otherwise 0
- `waitrequest_cpu`  out  1  stall to the CPU
- `read_ram` / `write_ram`  out  1  RAM strobes
- `addr_ram`  out  32  word-aligned byte address
- `byteenable_ram`  out  4  4'hF except on write-through writes
- `writedata_ram`  out  32  RAM write data
- `readdata_ram`  in  32  sampled at the edge where `read_ram`=1 and `waitrequest_ram`=0
- `waitrequest_ram`  in  1  RAM stall

## Operation
- Address split: word offset `addr[2+OW-1:2]`, where OW = log2(LINE_WORDS). Index is the next log2(SETS) bits. Tag is the remaining upper bits.
- Per line: valid, dirty (write-back mode only), tag, LINE_WORDS data words.
- FSM states: LOOKUP, EVICT, FILL, WT_WRITE.
- LOOKUP, no request: `waitrequest_cpu`=0.
- LOOKUP, read hit: completes combinationally with zero wait.
- LOOKUP, read miss: if the victim is valid and dirty, go to EVICT; otherwise go to FILL.
- LOOKUP, write, WRITE_BACK=1, hit: byte-merge into the line, set dirty, zero wait.
- LOOKUP, write, WRITE_BACK=1, miss: allocate via EVICT/FILL, then complete as a hit.
- LOOKUP, write, WRITE_BACK=0: go to WT_WRITE. On a hit, the line is byte-merged at completion; on a miss the line is untouched.
- EVICT: write the victim's words 0..LINE_WORDS-1 to the victim address, one per accepted transfer. Then go to FILL.
- FILL: read words 0..LINE_WORDS-1 of the requested line. After the last word, set valid, clear dirty, write the tag, and return to LOOKUP. The retried request then hits.
- WT_WRITE: `write_ram`=1 carrying CPU addr/data/byteenable; `waitrequest_cpu`=`waitrequest_ram`. On accept, return to LOOKUP.
- Simultaneous `read_cpu` and `write_cpu`: write wins.
- The CPU holds addr/data/strobes stable while `waitrequest_cpu`=1 (Avalon rule). Behaviour is undefined if it does not.
- Word counter wraps to 0 on leaving EVICT/FILL.

## Timing
- Reset values: `read_ram`=0, `write_ram`=0, `addr_ram`=0, `writedata_ram`=0, `byteenable_ram`=4'hF, `readdata_cpu`=0. `waitrequest_cpu`=0 while the CPU is idle.
- All RAM strobes, addresses and data are registered and held stable while `waitrequest_ram`=1.
- A RAM transfer completes on each edge where its strobe is 1 and `waitrequest_ram`=0.
- Latencies below assume zero-wait RAM (each added RAM stall cycle adds one cycle):
  - hit: 0 wait cycles
  - clean miss: `waitrequest_cpu` high for LINE_WORDS+1 cycles
  - dirty miss: high for 2·LINE_WORDS+1 cycles
  - write-through: high for 1 cycle
- Reset mid-transfer: strobes drop immediately (asynchronously), the partial line stays invalid, and no RAM write is retried.

## Structure
- Package `l1cache_pkg`: state enum, `addr_t`/`word_t` typedefs, and width helper functions (offset/index/tag widths from SETS and LINE_WORDS).
- One sub-module, `l1cache_data_array`: SETS×LINE_WORDS×32 storage with asynchronous read and byte-enabled synchronous write. Tag/valid/dirty storage and the FSM stay in `l1cache_wb`.

## Test plan
Common setup: defaults SETS=16, LINE_WORDS=4; RAM model word i = 16·i+1; zero-wait RAM unless stated.
- Read 0x40 after reset → 4 RAM reads at 0x40, 0x44, 0x48, 0x4C; `waitrequest_cpu` high for 5 cycles; `readdata_cpu`=257. A following read of 0x44 gives 273 with no RAM activity.
- Write 0x44, data 0xDEADBEEF, byteenable 4'b0011 → no RAM traffic, zero wait. A read of 0x44 then returns 0x0000BEEF.
- Read 0x440 (same index, new tag) → 4 writes to 0x40..0x4C (second word 0x0000BEEF), then 4 reads; `waitrequest_cpu` high for 9 cycles; `readdata_cpu`=4353.
- With `waitrequest_ram` held high for 3 cycles on fill word 2 → `addr_ram`=0x48 and `read_ram` stay stable; miss latency grows by 3.
- WRITE_BACK=0: write 0x80, data 0x12345678, byteenable 4'b1000 → one `write_ram` with that address, data and byteenable; `waitrequest_cpu` high for 1 cycle; no `read_ram`.
- Assert `reset` during fill word 2 → `read_ram`=0 in the same cycle. After release, a read of 0x40 misses again and issues 4 RAM reads.
